// File: rtl/dcache_direct_mapped_if.sv
// rtl/dcache_direct_mapped_if.sv - CPU-side and memory-side bus bundle for the data cache
interface dcache_direct_mapped_if #(
  parameter int ADDR_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;
  logic [7:0]        readdata;
  logic              busywait;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_writedata;
  logic [7:0]        mem_readdata;
  logic              mem_busywait;

  // master: the CPU plus data memory surrounding the cache
  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// rtl/dcache_direct_mapped.sv - direct-mapped write-back write-allocate data cache
module dcache_direct_mapped #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_W      = 8
) (
  input  logic clock,
  input  logic reset,
  dcache_direct_mapped_if.slave bus
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int TW = ADDR_W - IW - OW;
  localparam logic [OW-1:0] LAST = OW'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
  state_t state, state_n;

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TW-1:0]       tag_arr  [NUM_SETS];
  logic [7:0]          data_arr [NUM_SETS][BLOCK_BYTES];
  logic [7:0]          line_buf [BLOCK_BYTES];

  logic [TW-1:0]       miss_tag, old_tag;
  logic [IW-1:0]       miss_idx;
  logic [OW-1:0]       k;
  logic                mem_read_q, mem_write_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [7:0]          mem_writedata_q;

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [OW-1:0] off;
  logic          req, hit, write_hit, byte_done;

  assign tag = bus.address[ADDR_W-1 -: TW];
  assign idx = bus.address[OW +: IW];
  assign off = bus.address[OW-1:0];

  // read and write together is treated as no request at all
  assign req       = bus.read ^ bus.write;
  assign hit       = valid[idx] && (tag_arr[idx] == tag);
  assign write_hit = (state == IDLE) && bus.write && !bus.read && hit;
  assign byte_done = (mem_read_q || mem_write_q) && !bus.mem_busywait;

  assign bus.readdata      = (bus.read && !bus.write && hit) ? data_arr[idx][off] : 8'h00;
  assign bus.busywait      = !reset && req && ((state != IDLE) || !hit);
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (req && !hit) state_n = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
      WRITEBACK: if (mem_write_q && byte_done && k == LAST) state_n = FETCH;
      FETCH:     if (mem_read_q && byte_done && k == LAST) state_n = UPDATE;
      UPDATE:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Control and memory handshake. Each byte is issued on one edge and retired on the first
  // later edge without mem_busywait; the retire edge drops the request, giving the one-cycle gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid           <= '0;
      dirty           <= '0;
      k               <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write_hit) dirty[idx] <= 1'b1;
          if (req && !hit) begin
            miss_tag <= tag;
            miss_idx <= idx;
            old_tag  <= tag_arr[idx];
            k        <= '0;
          end
        end
        WRITEBACK: begin
          if (!mem_write_q) begin
            mem_write_q     <= 1'b1;
            mem_address_q   <= {old_tag, miss_idx, k};
            mem_writedata_q <= data_arr[miss_idx][k];
          end else if (!bus.mem_busywait) begin
            mem_write_q <= 1'b0;
            k           <= k + OW'(1);  // wraps to 0 after the last byte, ready for FETCH
          end
        end
        FETCH: begin
          if (!mem_read_q) begin
            mem_read_q    <= 1'b1;
            mem_address_q <= {miss_tag, miss_idx, k};
          end else if (!bus.mem_busywait) begin
            mem_read_q <= 1'b0;
            k          <= k + OW'(1);
          end
        end
        UPDATE: begin
          valid[miss_idx] <= 1'b1;
          dirty[miss_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == FETCH && mem_read_q && !bus.mem_busywait)
        line_buf[k] <= bus.mem_readdata;
      if (state == UPDATE) begin
        for (int b = 0; b < BLOCK_BYTES; b++) data_arr[miss_idx][b] <= line_buf[b];
        tag_arr[miss_idx] <= miss_tag;
      end else if (write_hit) begin
        data_arr[idx][off] <= bus.writedata;
      end
    end
  end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb/tb_dcache_direct_mapped.sv - directed scoreboard bench for dcache_direct_mapped
module tb_dcache_direct_mapped;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dcache_direct_mapped_if #(.ADDR_W(8)) bus ();
  dcache_direct_mapped dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
  } xact_t;

  xact_t logq[$];
  xact_t expq[$];
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic mem_load;
  int   lat;
  int   wcnt;
  int   req_cycles;
  int   vectors = 0;
  int   errors  = 0;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37) ^ 8'h5C);
  endfunction

  // Data memory: busy for lat cycles after each request edge, acts on the completing edge
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (wcnt < lat);
  assign bus.mem_readdata = mem[bus.mem_address];

  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      wcnt       <= 0;
      req_cycles <= 0;
    end else if (bus.mem_read || bus.mem_write) begin
      req_cycles <= req_cycles + 1;
      if (!bus.mem_busywait) begin
        logq.push_back({bus.mem_write, bus.mem_address,
                        bus.mem_write ? bus.mem_writedata : bus.mem_readdata});
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic expect_fetch(input logic [7:0] base);
    for (int i = 0; i < 4; i++) expq.push_back({1'b0, base + 8'(i), ref_mem[base + 8'(i)]});
  endtask

  task automatic compare_log(input string name);
    xact_t a, e;
    check({name, "/xact_count"}, logq.size(), expq.size());
    while (logq.size() > 0 && expq.size() > 0) begin
      a = logq.pop_front();
      e = expq.pop_front();
      check({name, "/xact"}, {15'd0, a}, {15'd0, e});
    end
    logq.delete();
    expq.delete();
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        input logic exp_busy0, input logic [7:0] exp_rd, input string name);
    int n;
    @(posedge clock); #1;
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    @(negedge clock);
    check({name, "/busy_first"}, bus.busywait, exp_busy0);
    n = 0;
    while (bus.busywait !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({name, "/busy_released"}, bus.busywait, 1'b0);
    if (rd) check({name, "/readdata"}, bus.readdata, exp_rd);
    @(posedge clock); #1;
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  initial begin
    int n;
    int rc0;
    reset = 1'b1; mem_load = 1'b1; lat = 2;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    repeat (2) @(posedge clock);
    #1 mem_load = 1'b0;
    @(negedge clock);
    check("reset/busywait", bus.busywait, 1'b0);
    check("reset/mem_read", bus.mem_read, 1'b0);
    check("reset/mem_write", bus.mem_write, 1'b0);
    check("reset/mem_address", bus.mem_address, 8'h00);
    check("reset/mem_writedata", bus.mem_writedata, 8'h00);
    check("reset/readdata", bus.readdata, 8'h00);
    @(posedge clock); #1 reset = 1'b0;

    // cold read miss
    expect_fetch(8'h00);
    access(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, ref_mem[8'h00], "t1");
    compare_log("t1");

    // read hit in the refilled line
    rc0 = req_cycles;
    access(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, ref_mem[8'h03], "t2");
    check("t2/no_mem_req", req_cycles, rc0);
    compare_log("t2");

    // write miss allocates, store lands in the cache only
    lat = 0;
    expect_fetch(8'h04);
    access(1'b0, 1'b1, 8'h05, 8'hAB, 1'b1, 8'h00, "t3w");
    compare_log("t3w");
    access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hAB, "t3r");
    check("t3/dirty1", dut.dirty[1], 1'b1);
    check("t3/mem05", mem[8'h05], ref_mem[8'h05]);

    // conflict miss evicts the dirty line before refilling
    lat = 3;
    expq.push_back({1'b1, 8'h04, ref_mem[8'h04]});
    expq.push_back({1'b1, 8'h05, 8'hAB});
    expq.push_back({1'b1, 8'h06, ref_mem[8'h06]});
    expq.push_back({1'b1, 8'h07, ref_mem[8'h07]});
    ref_mem[8'h05] = 8'hAB;
    expect_fetch(8'h24);
    access(1'b1, 1'b0, 8'h25, 8'h00, 1'b1, ref_mem[8'h25], "t4");
    compare_log("t4");
    check("t4/mem05", mem[8'h05], 8'hAB);

    // reset while byte 2 of a refill is outstanding
    lat = 2;
    @(posedge clock); #1;
    bus.read = 1'b1; bus.address = 8'h40;
    n = 0;
    while (!(logq.size() == 2 && bus.mem_read === 1'b1) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("t5/reached_byte2", logq.size(), 2);
    reset = 1'b1;
    @(posedge clock); #1;
    check("t5/mem_read", bus.mem_read, 1'b0);
    check("t5/busywait", bus.busywait, 1'b0);
    check("t5/valid0", dut.valid[0], 1'b0);
    reset = 1'b0; bus.read = 1'b0;
    logq.delete();
    expq.delete();
    expect_fetch(8'h40);
    access(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, ref_mem[8'h40], "t5");
    compare_log("t5");

    // read and write together is not a request
    rc0 = req_cycles;
    access(1'b1, 1'b1, 8'h10, 8'h77, 1'b0, 8'h00, "t6");
    repeat (3) @(posedge clock);
    #1;
    check("t6/no_mem_req", req_cycles, rc0);
    check("t6/valid4", dut.valid[4], 1'b0);
    expect_fetch(8'h10);
    access(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, ref_mem[8'h10], "t6r");
    compare_log("t6r");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
